// File: rtl/wifi_rx_demap_sched.sv
// Sequencer feeding the WiFi RX demapper serializers.
//
// Accepts demapped symbols (1/2/4/6 bits) over a valid/ready handshake and holds
// each one on dm_data for exactly bits-per-symbol cycles with dm_valid high for
// the whole window. Consecutive symbols are issued back-to-back when upstream keeps
// up, so the serializer bit counter never slips. Also counts symbols per frame,
// pulses done at frame end and counts mid-frame upstream gaps.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   start, abort         frame start (IDLE only), synchronous abort (any state)
//   cfg_mod, cfg_nsym    modulation and frame length, sampled on start
//   sym_valid/sym_ready  upstream symbol handshake, sym_data LSB-aligned
//   dm_valid, dm_data    serializer input window
//   dm_sel               latched modulation, selects the serializer instance
//   bit_phase            bit index within the current symbol
//   busy, done           frame in progress, one-cycle end-of-frame pulse
//   underrun_cnt         saturating count of mid-frame gaps, cleared on start
module wifi_rx_demap_sched #(
  parameter int unsigned SYM_W = 6,
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_mod,
  input  logic [CNT_W-1:0] cfg_nsym,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  output logic             sym_ready,
  output logic             dm_valid,
  output logic [SYM_W-1:0] dm_data,
  output logic [1:0]       dm_sel,
  output logic [2:0]       bit_phase,
  output logic             busy,
  output logic             done,
  output logic [7:0]       underrun_cnt
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic               dm_valid_q, dm_valid_d;
  logic [SYM_W-1:0]   dm_data_q, dm_data_d;
  logic [1:0]         dm_sel_q, dm_sel_d;
  logic [2:0]         bit_phase_q, bit_phase_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [7:0]         underrun_q, underrun_d;

  logic [2:0]         bps_last;
  logic               last_phase;
  logic               more_syms;

  // Last bit index of a symbol for the latched modulation (BPS-1).
  always_comb begin
    bps_last = 3'd0;
    unique case (dm_sel_q)
      2'b00: bps_last = 3'd0;
      2'b01: bps_last = 3'd1;
      2'b10: bps_last = 3'd3;
      2'b11: bps_last = 3'd5;
      default: bps_last = 3'd0;
    endcase
  end

  assign last_phase = (bit_phase_q == bps_last);
  assign more_syms  = (remaining_q > CNT_W'(1));

  always_comb begin
    sym_ready = 1'b0;
    unique case (state_q)
      StLoad:  sym_ready = 1'b1;
      // Ready only on the final bit so the next symbol lands with no valid gap.
      StShift: sym_ready = last_phase && more_syms;
      default: sym_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dm_valid_d  = dm_valid_q;
    dm_data_d   = dm_data_q;
    dm_sel_d    = dm_sel_q;
    bit_phase_d = bit_phase_q;
    remaining_d = remaining_q;
    underrun_d  = underrun_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dm_sel_d    = cfg_mod;
          remaining_d = cfg_nsym;
          underrun_d  = 8'd0;
          state_d     = (cfg_nsym == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        dm_valid_d = 1'b0;
        if (sym_valid) begin
          dm_data_d   = sym_data;
          dm_valid_d  = 1'b1;
          bit_phase_d = 3'd0;
          state_d     = StShift;
        end
      end
      StShift: begin
        if (!last_phase) begin
          bit_phase_d = bit_phase_q + 3'd1;
        end else begin
          remaining_d = remaining_q - CNT_W'(1);
          bit_phase_d = 3'd0;
          if (!more_syms) begin
            dm_valid_d = 1'b0;
            state_d    = StDone;
          end else if (sym_valid) begin
            dm_data_d = sym_data;
          end else begin
            dm_valid_d = 1'b0;
            state_d    = StLoad;
            if (underrun_q != 8'hFF) begin
              underrun_d = underrun_q + 8'd1;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a start in IDLE.
    if (abort) begin
      state_d     = StIdle;
      dm_valid_d  = 1'b0;
      bit_phase_d = 3'd0;
      dm_data_d   = dm_data_q;
      dm_sel_d    = dm_sel_q;
      remaining_d = remaining_q;
      underrun_d  = underrun_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      dm_valid_q  <= 1'b0;
      dm_data_q   <= '0;
      dm_sel_q    <= 2'b00;
      bit_phase_q <= 3'd0;
      remaining_q <= '0;
      underrun_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      dm_valid_q  <= dm_valid_d;
      dm_data_q   <= dm_data_d;
      dm_sel_q    <= dm_sel_d;
      bit_phase_q <= bit_phase_d;
      remaining_q <= remaining_d;
      underrun_q  <= underrun_d;
    end
  end

  assign dm_valid     = dm_valid_q;
  assign dm_data      = dm_data_q;
  assign dm_sel       = dm_sel_q;
  assign bit_phase    = bit_phase_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_wifi_rx_demap_sched.sv
// Directed bench for wifi_rx_demap_sched: walks modulation modes, back-to-back and
// late symbols, zero-length frames, abort and asynchronous reset mid-frame.
module tb_wifi_rx_demap_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  cfg_mod;
  logic [11:0] cfg_nsym;
  logic        sym_valid;
  logic [5:0]  sym_data;
  logic        sym_ready;
  logic        dm_valid;
  logic [5:0]  dm_data;
  logic [1:0]  dm_sel;
  logic [2:0]  bit_phase;
  logic        busy;
  logic        done;
  logic [7:0]  underrun_cnt;

  int total;
  int passes;

  wifi_rx_demap_sched #(.SYM_W(6), .CNT_W(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cfg_mod      (cfg_mod),
    .cfg_nsym     (cfg_nsym),
    .sym_valid    (sym_valid),
    .sym_data     (sym_data),
    .sym_ready    (sym_ready),
    .dm_valid     (dm_valid),
    .dm_data      (dm_data),
    .dm_sel       (dm_sel),
    .bit_phase    (bit_phase),
    .busy         (busy),
    .done         (done),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dmv"},  32'(dm_valid), 32'd0);
    chk({tag, "_rdy"},  32'(sym_ready), 32'd0);
  endtask

  logic [5:0] d16 [3];
  logic [5:0] dbp [4];
  logic [5:0] dqp [5];
  int acc;

  initial begin
    total = 0;
    passes = 0;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_mod = 2'b00;
    cfg_nsym = 12'd0;
    sym_valid = 1'b0;
    sym_data = 6'd0;
    d16[0] = 6'hA; d16[1] = 6'h5; d16[2] = 6'hF;
    dbp[0] = 6'h1; dbp[1] = 6'h0; dbp[2] = 6'h1; dbp[3] = 6'h1;
    dqp[0] = 6'h1; dqp[1] = 6'h2; dqp[2] = 6'h3; dqp[3] = 6'h0; dqp[4] = 6'h1;

    #1;
    chk_idle("rst");
    chk("rst_data", 32'(dm_data), 32'd0);
    chk("rst_sel", 32'(dm_sel), 32'd0);
    chk("rst_phase", 32'(bit_phase), 32'd0);
    chk("rst_und", 32'(underrun_cnt), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // 1: 16QAM, 3 back-to-back symbols
    cfg_mod = 2'b10; cfg_nsym = 12'd3; start = 1'b1;
    sym_valid = 1'b1; sym_data = d16[0];
    chk("t1_idle_rdy", 32'(sym_ready), 32'd0);
    step();
    start = 1'b0;
    chk("t1_load_rdy", 32'(sym_ready), 32'd1);
    chk("t1_load_dmv", 32'(dm_valid), 32'd0);
    chk("t1_sel", 32'(dm_sel), 32'd2);
    step();
    for (int s = 0; s < 3; s++) begin
      for (int p = 0; p < 4; p++) begin
        chk("t1_dmv", 32'(dm_valid), 32'd1);
        chk("t1_data", 32'(dm_data), 32'(d16[s]));
        chk("t1_phase", 32'(bit_phase), 32'(p));
        chk("t1_rdy", 32'(sym_ready), 32'((p == 3) && (s < 2)));
        if (p == 3 && s < 2) sym_data = d16[s+1];
        step();
      end
    end
    sym_valid = 1'b0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_done_dmv", 32'(dm_valid), 32'd0);
    chk("t1_und", 32'(underrun_cnt), 32'd0);
    step();
    chk_idle("t1_end");

    // 2: 64QAM, second symbol 3 cycles late
    cfg_mod = 2'b11; cfg_nsym = 12'd2; start = 1'b1;
    sym_valid = 1'b1; sym_data = 6'h2D;
    step();
    start = 1'b0;
    step();
    sym_valid = 1'b0;
    for (int p = 0; p < 6; p++) begin
      chk("t2_dmv_a", 32'(dm_valid), 32'd1);
      chk("t2_data_a", 32'(dm_data), 32'h2D);
      chk("t2_phase_a", 32'(bit_phase), 32'(p));
      step();
    end
    chk("t2_gap_dmv", 32'(dm_valid), 32'd0);
    chk("t2_gap_rdy", 32'(sym_ready), 32'd1);
    chk("t2_und", 32'(underrun_cnt), 32'd1);
    step();
    step();
    sym_valid = 1'b1; sym_data = 6'h13;
    step();
    sym_valid = 1'b0;
    for (int p = 0; p < 6; p++) begin
      chk("t2_dmv_b", 32'(dm_valid), 32'd1);
      chk("t2_data_b", 32'(dm_data), 32'h13);
      chk("t2_rdy_b", 32'(sym_ready), 32'd0);
      step();
    end
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_und_end", 32'(underrun_cnt), 32'd1);
    step();
    chk_idle("t2_end");

    // 3: BPSK, 4 continuous symbols
    cfg_mod = 2'b00; cfg_nsym = 12'd4; start = 1'b1;
    sym_valid = 1'b1; sym_data = dbp[0];
    acc = 0;
    step();
    start = 1'b0;
    if (sym_ready) acc++;
    chk("t3_load_rdy", 32'(sym_ready), 32'd1);
    step();
    for (int s = 0; s < 4; s++) begin
      chk("t3_dmv", 32'(dm_valid), 32'd1);
      chk("t3_data", 32'(dm_data), 32'(dbp[s]));
      chk("t3_rdy", 32'(sym_ready), 32'(s < 3));
      if (sym_ready) acc++;
      if (s < 3) sym_data = dbp[s+1];
      step();
    end
    sym_valid = 1'b0;
    chk("t3_acc", 32'(acc), 32'd4);
    chk("t3_done", 32'(done), 32'd1);
    step();
    chk_idle("t3_end");

    // 4: zero-length frame
    cfg_nsym = 12'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_rdy", 32'(sym_ready), 32'd0);
    chk("t4_dmv", 32'(dm_valid), 32'd0);
    step();
    chk_idle("t4_end");

    // 5: QPSK, abort at bit_phase 1 of the third symbol
    cfg_mod = 2'b01; cfg_nsym = 12'd5; start = 1'b1;
    sym_valid = 1'b1; sym_data = dqp[0];
    step();
    start = 1'b0;
    step();
    for (int s = 0; s < 2; s++) begin
      step();
      sym_data = dqp[s+1];
      step();
    end
    step();
    chk("t5_phase", 32'(bit_phase), 32'd1);
    chk("t5_data", 32'(dm_data), 32'(dqp[2]));
    abort = 1'b1;
    step();
    abort = 1'b0;
    sym_valid = 1'b0;
    chk_idle("t5_abort");
    chk("t5_ab_phase", 32'(bit_phase), 32'd0);
    step();
    chk("t5_nodone", 32'(done), 32'd0);
    // New frame; a start with different config mid-frame must be ignored.
    cfg_mod = 2'b01; cfg_nsym = 12'd1; start = 1'b1;
    sym_valid = 1'b1; sym_data = 6'h2;
    step();
    start = 1'b0;
    step();
    sym_valid = 1'b0;
    cfg_mod = 2'b11; start = 1'b1;
    chk("t5b_p0", 32'(bit_phase), 32'd0);
    chk("t5b_dmv", 32'(dm_valid), 32'd1);
    step();
    start = 1'b0;
    chk("t5b_p1", 32'(bit_phase), 32'd1);
    chk("t5b_sel", 32'(dm_sel), 32'd1);
    step();
    chk("t5b_done", 32'(done), 32'd1);
    step();
    chk_idle("t5b_end");

    // 6: asynchronous reset mid-SHIFT of a 16QAM frame
    cfg_mod = 2'b10; cfg_nsym = 12'd3; start = 1'b1;
    sym_valid = 1'b1; sym_data = 6'hC;
    step();
    start = 1'b0;
    step();
    step();
    chk("t6_pre_phase", 32'(bit_phase), 32'd1);
    reset = 1'b0;
    #1;
    chk_idle("t6_rst");
    chk("t6_data", 32'(dm_data), 32'd0);
    chk("t6_sel", 32'(dm_sel), 32'd0);
    chk("t6_phase", 32'(bit_phase), 32'd0);
    cfg_nsym = 12'd1; start = 1'b1; sym_valid = 1'b0;
    step();
    chk("t6_ign", 32'(busy), 32'd0);
    reset = 1'b1;
    step();
    start = 1'b0;
    chk("t6_acc_busy", 32'(busy), 32'd1);
    chk("t6_acc_sel", 32'(dm_sel), 32'd2);
    sym_valid = 1'b1; sym_data = 6'h7;
    step();
    sym_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      chk("t6_dmv", 32'(dm_valid), 32'd1);
      chk("t6_wdata", 32'(dm_data), 32'h7);
      step();
    end
    chk("t6_done", 32'(done), 32'd1);
    step();
    chk_idle("t6_end");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
